// File: rtl/onehot_decoder_3to8_seq.sv
// ---------------------------------------------------------------------------
// onehot_decoder_3to8_seq
//
// Registered 3-to-8 decoder. Turns an accepted 3-bit index back into a
// one-hot line that is held for PULSE_LEN cycles. It is the counterpart of
// the 8-to-3 priority encoder, for example to regenerate per-line
// acknowledge strobes from an encoded grant.
//
// Alongside the pulse, the block keeps a sticky mask of every index that has
// been served with in_en = 1. It raises a one-cycle dup flag when an index
// that is already in the mask is requested again.
//
// Parameters
//   PULSE_LEN  cycles each one-hot output is held (1..15)
//   CNT_W      hold-counter width, 2**CNT_W > PULSE_LEN
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    in_code/in_en are presented
//   in_ready    block can take a code this cycle (from state only)
//   in_code     index to decode, 0..7
//   in_en       1 = drive the decoded line, 0 = consume the code, drive Y = 0
//   Y           registered one-hot (or all-zero) output
//   y_valid     Y is being driven for an accepted code
//   served      sticky mask of indices accepted with in_en = 1
//   served_clr  synchronous clear of served
//   dup         one-cycle pulse, aligned with the first Y cycle, when the
//               accepted index was already set in served
//   busy        high while in DRIVE
//
// Handshake: a code is consumed on a rising edge where in_valid && in_ready.
// in_ready depends only on the registered state, never on in_valid, so a
// producer may hold in_valid and in_code stable until it sees the consuming
// edge. While in_ready is low, in_valid is ignored and nothing is consumed.
// ---------------------------------------------------------------------------
module onehot_decoder_3to8_seq #(
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_en,
    output logic [7:0] Y,
    output logic       y_valid,
    output logic [7:0] served,
    input  logic       served_clr,
    output logic       dup,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Counter value loaded on accept: the number of additional cycles the
    // pulse is held after its first cycle.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_LEN - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       y_d;
    logic             y_valid_d;
    logic [7:0]       served_d;
    logic             dup_d;
    logic             accept;
    logic [7:0]       code_onehot;

    // The last cycle of a pulse is also an accept slot. This lets a held
    // in_valid chain pulses back-to-back with no idle gap.
    assign in_ready    = (state_q == ST_IDLE) || (cnt_q == '0);
    assign accept      = in_valid && in_ready;
    assign busy        = (state_q == ST_DRIVE);
    assign code_onehot = 8'h01 << in_code;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = Y;
        y_valid_d = y_valid;

        if (accept) begin
            // The same reload applies from IDLE and from the final DRIVE cycle.
            y_d       = in_en ? code_onehot : 8'h00;
            y_valid_d = 1'b1;
            cnt_d     = RELOAD;
            state_d   = ST_DRIVE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Nothing to do; outputs already zero.
                end
                ST_DRIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        y_d       = 8'h00;
                        y_valid_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    y_d       = 8'h00;
                    y_valid_d = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Served mask and duplicate detection
    // -----------------------------------------------------------------------
    always_comb begin
        served_d = served;
        // The clear comes first, so a coinciding accept leaves only its own bit.
        if (served_clr) begin
            served_d = 8'h00;
        end
        if (accept && in_en) begin
            served_d = served_d | code_onehot;
        end
        // Looks at the mask before this edge, so a coinciding clear does
        // not hide a repeat request.
        dup_d = accept && in_en && served[in_code];
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            Y       <= 8'h00;
            y_valid <= 1'b0;
            served  <= 8'h00;
            dup     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            Y       <= y_d;
            y_valid <= y_valid_d;
            served  <= served_d;
            dup     <= dup_d;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_3to8_seq.sv
module tb_onehot_decoder_3to8_seq;

  localparam int NI = 4;  // instances with PULSE_LEN 3, 2, 4, 1

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       vld  [NI];
  logic [2:0] code [NI];
  logic       en   [NI];
  logic       clr  [NI];
  logic       rdy  [NI];
  logic [7:0] y    [NI];
  logic       yv   [NI];
  logic [7:0] srv  [NI];
  logic       dup  [NI];
  logic       busy [NI];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk8(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input int k, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %b expected %b at %0t", nm, k, act, exp, $time);
  endtask

  // ---------------- DUTs and reference models ----------------
  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int PL = (g == 0) ? 3 : (g == 1) ? 2 : (g == 2) ? 4 : 1;

    onehot_decoder_3to8_seq #(.PULSE_LEN(PL), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(vld[g]), .in_ready(rdy[g]), .in_code(code[g]), .in_en(en[g]),
      .Y(y[g]), .y_valid(yv[g]), .served(srv[g]), .served_clr(clr[g]),
      .dup(dup[g]), .busy(busy[g])
    );

    // Model: a queue of output cycles still to be shown; front = current
    // cycle. Each entry is {dup, Y}. A new code fits once at most one cycle
    // of the previous pulse remains.
    logic [8:0] pend [$];
    logic [7:0] m_srv;

    always @(posedge clk or posedge rst) begin
      logic acc;
      logic dv;
      if (rst) begin
        pend.delete();
        m_srv = 8'h00;
      end else begin
        acc = vld[g] && (pend.size() <= 1);
        dv = acc && en[g] && m_srv[code[g]];
        if (pend.size() > 0) pend.delete(0);
        if (acc)
          for (int i = 0; i < PL; i++)
            pend.push_back({(i == 0) && dv, en[g] ? 8'(1 << code[g]) : 8'h00});
        if (clr[g]) m_srv = 8'h00;
        if (acc && en[g]) m_srv[code[g]] = 1'b1;
      end
    end

    always @(negedge clk) begin
      logic [8:0] f;
      if (!rst) begin
        f = (pend.size() > 0) ? pend[0] : 9'h000;
        chk8("model_y", g, y[g], f[7:0]);
        chk1("model_yv", g, yv[g], pend.size() > 0);
        chk1("model_busy", g, busy[g], pend.size() > 0);
        chk1("model_dup", g, dup[g], f[8]);
        chk1("model_ready", g, rdy[g], pend.size() <= 1);
        chk8("model_served", g, srv[g], m_srv);
        chk1("onehot0", g, $onehot0(y[g]), 1'b1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int k, input logic v, input logic [2:0] c, input logic e, input logic cl);
    vld[k] = v; code[k] = c; en[k] = e; clr[k] = cl;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) drive(k, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic rand_drive();
    for (int k = 0; k < NI; k++)
      drive(k, $urandom_range(0, 99) < 70, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
  endtask

  // Send one code to an idle instance and follow the whole pulse.
  task automatic send_one(input int k, input logic [2:0] c, input logic e, input logic cl,
                          input logic exp_dup, input logic [7:0] exp_srv, input int plen);
    int n;
    drive(k, 1'b1, c, e, cl);
    @(posedge clk); #1;
    vld[k] = 1'b0; clr[k] = 1'b0;
    @(negedge clk);
    chk8("send_y", k, y[k], e ? 8'(1 << c) : 8'h00);
    chk1("send_yv", k, yv[k], 1'b1);
    chk1("send_dup", k, dup[k], exp_dup);
    chk8("send_served", k, srv[k], exp_srv);
    n = 0;
    while (yv[k] && n < 20) begin
      @(negedge clk);
      if (yv[k]) n++;
    end
    chk1("send_drain", k, yv[k], 1'b0);
    chk8("send_len", k, 8'(n), 8'(plen - 1));
  endtask

  // ---------------- vector table (PULSE_LEN = 1 instance) ----------------
  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       e;
    logic       cl;
    logic [7:0] ey;
    logic       eyv;
    logic [7:0] es;
    logic       ed;
  } vec_t;
  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 3'(i), 1'b1, 1'b0, 8'(1 << i), 1'b1, 8'((2 << i) - 1), 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0};
    tbl[9]  = '{1'b1, 3'd3, 1'b1, 1'b0, 8'h08, 1'b1, 8'hFF, 1'b1};
    tbl[10] = '{1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[12] = '{1'b1, 3'd6, 1'b1, 1'b1, 8'h40, 1'b1, 8'h40, 1'b0};
    tbl[13] = '{1'b1, 3'd6, 1'b1, 1'b1, 8'h40, 1'b1, 8'h40, 1'b1};
    tbl[14] = '{1'b1, 3'd2, 1'b1, 1'b0, 8'h04, 1'b1, 8'h44, 1'b0};
    tbl[15] = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h44, 1'b0};

    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < NI; k++) begin
      chk8("rst_y", k, y[k], 8'h00);
      chk1("rst_yv", k, yv[k], 1'b0);
      chk8("rst_served", k, srv[k], 8'h00);
      chk1("rst_dup", k, dup[k], 1'b0);
      chk1("rst_busy", k, busy[k], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk1("rst_ready", k, rdy[k], 1'b1);

    // Traffic, then an asynchronous reset in the middle of a cycle.
    repeat (6) begin @(posedge clk); #1; rand_drive(); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk8("arst_y", k, y[k], 8'h00);
      chk1("arst_yv", k, yv[k], 1'b0);
      chk8("arst_served", k, srv[k], 8'h00);
      chk1("arst_dup", k, dup[k], 1'b0);
      chk1("arst_busy", k, busy[k], 1'b0);
    end
    idle_all();
    @(negedge clk);
    rst = 1'b0;

    // Single code 5, PULSE_LEN = 3.
    drive(0, 1'b1, 3'd5, 1'b1, 1'b0);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk8("s1_y", 0, y[0], 8'h20);
      chk1("s1_yv", 0, yv[0], 1'b1);
      chk1("s1_busy", 0, busy[0], 1'b1);
      chk1("s1_ready", 0, rdy[0], i == 2);
      chk1("s1_dup", 0, dup[0], 1'b0);
      chk8("s1_served", 0, srv[0], 8'h20);
    end
    @(negedge clk);
    chk8("s1_end_y", 0, y[0], 8'h00);
    chk1("s1_end_yv", 0, yv[0], 1'b0);
    chk1("s1_end_busy", 0, busy[0], 1'b0);

    // Back-to-back codes 0 then 7, PULSE_LEN = 2.
    drive(1, 1'b1, 3'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    code[1] = 3'd7;
    @(negedge clk);
    chk8("b2b_y0", 1, y[1], 8'h01);
    chk1("b2b_rdy0", 1, rdy[1], 1'b0);
    @(negedge clk);
    chk8("b2b_y1", 1, y[1], 8'h01);
    chk1("b2b_rdy1", 1, rdy[1], 1'b1);
    @(posedge clk); #1;
    vld[1] = 1'b0;
    @(negedge clk);
    chk8("b2b_y2", 1, y[1], 8'h80);
    chk1("b2b_yv2", 1, yv[1], 1'b1);
    @(negedge clk);
    chk8("b2b_y3", 1, y[1], 8'h80);
    @(negedge clk);
    chk8("b2b_y4", 1, y[1], 8'h00);
    chk1("b2b_yv4", 1, yv[1], 1'b0);
    chk8("b2b_served", 1, srv[1], 8'h81);

    // Stall: code 2 accepted, code 6 held waiting, PULSE_LEN = 4.
    drive(2, 1'b1, 3'd2, 1'b1, 1'b0);
    @(posedge clk); #1;
    code[2] = 3'd6;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk8("stall_ya", 2, y[2], 8'h04);
      chk1("stall_rdya", 2, rdy[2], i == 3);
    end
    @(posedge clk); #1;
    vld[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk8("stall_yb", 2, y[2], 8'h40);
      chk1("stall_rdyb", 2, rdy[2], i == 3);
    end
    @(negedge clk);
    chk8("stall_end", 2, y[2], 8'h00);

    // Disable path: code 3 with in_en = 0 leaves served untouched.
    send_one(0, 3'd3, 1'b0, 1'b0, 1'b0, 8'h20, 3);

    // Dup and clear, PULSE_LEN = 2.
    clr[1] = 1'b1;
    @(posedge clk); #1;
    clr[1] = 1'b0;
    @(negedge clk);
    chk8("clr_alone", 1, srv[1], 8'h00);
    send_one(1, 3'd1, 1'b1, 1'b0, 1'b0, 8'h02, 2);
    send_one(1, 3'd4, 1'b1, 1'b0, 1'b0, 8'h12, 2);
    send_one(1, 3'd1, 1'b1, 1'b0, 1'b1, 8'h12, 2);
    send_one(1, 3'd4, 1'b1, 1'b1, 1'b1, 8'h10, 2);

    // Table-driven sweep on the PULSE_LEN = 1 instance, one vector per cycle.
    for (int i = 0; i < 16; i++) begin
      drive(3, tbl[i].v, tbl[i].c, tbl[i].e, tbl[i].cl);
      @(posedge clk); #2;
      chk8($sformatf("tbl%0d_y", i), 3, y[3], tbl[i].ey);
      chk1($sformatf("tbl%0d_yv", i), 3, yv[3], tbl[i].eyv);
      chk8($sformatf("tbl%0d_served", i), 3, srv[3], tbl[i].es);
      chk1($sformatf("tbl%0d_dup", i), 3, dup[3], tbl[i].ed);
    end
    idle_all();

    // Random traffic on all instances, checked against the models.
    repeat (600) begin @(posedge clk); #1; rand_drive(); end
    idle_all();
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
